// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle MIPS-style datapath: Moore decode of the state,
// with PC/IR load strobes resolved against the memory handshake and branch flag.
module multicycle_ctrl (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] op_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic [3:0] state_o,
  output logic       pc_write_o,
  output logic [1:0] pc_src_o,
  output logic       i_or_d_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] ALUOp_o,
  output logic       illegal_o
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    REXEC  = 4'd6,
    RWB    = 4'd7,
    BEQ    = 4'd8,
    JMP    = 4'd9,
    IEXEC  = 4'd10,
    IWB    = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;

  // Raw (ungated) strobes; reset masks them combinationally below.
  logic pc_write_raw, ir_write_raw, mem_read_raw, mem_write_raw, reg_write_raw;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d       = FETCH;
    illegal_d     = 1'b0;
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    mem_read_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    pc_src_o      = 2'b00;
    i_or_d_o      = 1'b0;
    reg_dst_o     = 1'b0;
    mem_to_reg_o  = 1'b0;
    alu_src_a_o   = 1'b0;
    alu_src_b_o   = 2'b00;
    ALUOp_o       = 3'b000;
    unique case (state_q)
      FETCH: begin
        mem_read_raw = 1'b1;
        alu_src_b_o  = 2'b01;
        ir_write_raw = mem_ready_i;
        pc_write_raw = mem_ready_i;
        state_d      = mem_ready_i ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b_o = 2'b11;
        case (op_i)
          OP_LW, OP_SW:     state_d = MEMADR;
          OP_RTYP:          state_d = REXEC;
          OP_BEQ:           state_d = BEQ;
          OP_J:             state_d = JMP;
          OP_ADDI, OP_SLTI: state_d = IEXEC;
          default: begin
            state_d   = FETCH;
            illegal_d = 1'b1;   // registered so it shows in the following FETCH
          end
        endcase
      end
      MEMADR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        state_d     = (op_i == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_read_raw = 1'b1;
        i_or_d_o     = 1'b1;
        state_d      = mem_ready_i ? MEMWB : MEMRD;
      end
      MEMWB: begin
        reg_write_raw = 1'b1;
        mem_to_reg_o  = 1'b1;
      end
      MEMWR: begin
        mem_write_raw = 1'b1;
        i_or_d_o      = 1'b1;
        state_d       = mem_ready_i ? FETCH : MEMWR;
      end
      REXEC: begin
        alu_src_a_o = 1'b1;
        ALUOp_o     = 3'b010;
        state_d     = RWB;
      end
      RWB: begin
        reg_write_raw = 1'b1;
        reg_dst_o     = 1'b1;
      end
      BEQ: begin
        alu_src_a_o  = 1'b1;
        ALUOp_o      = 3'b001;
        pc_src_o     = 2'b01;
        pc_write_raw = zero_i;
      end
      JMP: begin
        pc_src_o     = 2'b10;
        pc_write_raw = 1'b1;
      end
      IEXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        ALUOp_o     = (op_i == OP_SLTI) ? 3'b011 : 3'b000;
        state_d     = IWB;
      end
      IWB: begin
        reg_write_raw = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  assign state_o     = state_q;
  assign illegal_o   = illegal_q;
  assign pc_write_o  = pc_write_raw  & rst_i;
  assign ir_write_o  = ir_write_raw  & rst_i;
  assign mem_read_o  = mem_read_raw  & rst_i;
  assign mem_write_o = mem_write_raw & rst_i;
  assign reg_write_o = reg_write_raw & rst_i;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed test of the multicycle control FSM with hand-computed expectations.
module tb_multicycle_ctrl;
  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [5:0] op_i;
  logic       zero_i;
  logic       mem_ready_i;
  logic [3:0] state_o;
  logic       pc_write_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o;
  logic       reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o, illegal_o;
  logic [1:0] pc_src_o, alu_src_b_o;
  logic [2:0] ALUOp_o;

  int n_vec = 0;
  int n_err = 0;

  multicycle_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .op_i(op_i), .zero_i(zero_i),
    .mem_ready_i(mem_ready_i), .state_o(state_o), .pc_write_o(pc_write_o),
    .pc_src_o(pc_src_o), .i_or_d_o(i_or_d_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .ir_write_o(ir_write_o), .reg_dst_o(reg_dst_o),
    .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .ALUOp_o(ALUOp_o),
    .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  initial begin
    rst_i = 1'b1; op_i = 6'd0; zero_i = 1'b0; mem_ready_i = 1'b0;
    #1 rst_i = 1'b0;
    #1;
    chk("rst_state", state_o, 0);
    chk("rst_mrd", mem_read_o, 0);
    chk("rst_ill", illegal_o, 0);
    step();
    chk("rst_hold_state", state_o, 0);
    chk("rst_hold_irw", ir_write_o, 0);

    // lw, zero wait states: 0,1,2,3,4,0
    rst_i = 1'b1; op_i = 6'b100011; mem_ready_i = 1'b1;
    #1;
    chk("lw_fetch_state", state_o, 0);
    chk("lw_fetch_mrd", mem_read_o, 1);
    chk("lw_fetch_irw", ir_write_o, 1);
    chk("lw_fetch_pcw", pc_write_o, 1);
    chk("lw_fetch_srcb", alu_src_b_o, 1);
    chk("lw_fetch_rw", reg_write_o, 0);
    step(); chk("lw_dec", state_o, 1); chk("lw_dec_srcb", alu_src_b_o, 3);
    chk("lw_dec_rw", reg_write_o, 0);
    step(); chk("lw_adr", state_o, 2); chk("lw_adr_srca", alu_src_a_o, 1);
    chk("lw_adr_rw", reg_write_o, 0);
    step(); chk("lw_rd", state_o, 3); chk("lw_rd_mrd", mem_read_o, 1);
    chk("lw_rd_iord", i_or_d_o, 1); chk("lw_rd_rw", reg_write_o, 0);
    step(); chk("lw_wb", state_o, 4); chk("lw_wb_rw", reg_write_o, 1);
    chk("lw_wb_m2r", mem_to_reg_o, 1);
    step(); chk("lw_done", state_o, 0);

    // sw with 3 wait cycles in MEMWR: 7 cycles total
    op_i = 6'b101011;
    step(); chk("sw_dec", state_o, 1);
    step(); chk("sw_adr", state_o, 2);
    step(); chk("sw_wr", state_o, 5);
    mem_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready_i = 1'b1;
      #1;
      chk("sw_wr_hold", state_o, 5);
      chk("sw_wr_mw", mem_write_o, 1);
      if (i < 3) step();
    end
    step(); chk("sw_done", state_o, 0); chk("sw_done_mw", mem_write_o, 0);

    // beq taken / not taken
    op_i = 6'b000100; zero_i = 1'b1;
    step(); step();
    chk("beq1_state", state_o, 8); chk("beq1_pcw", pc_write_o, 1);
    chk("beq1_src", pc_src_o, 1); chk("beq1_alu", ALUOp_o, 1);
    step(); chk("beq1_done", state_o, 0);
    zero_i = 1'b0;
    step(); step();
    chk("beq0_state", state_o, 8); chk("beq0_pcw", pc_write_o, 0);
    chk("beq0_src", pc_src_o, 1);
    step(); chk("beq0_done", state_o, 0);

    // j
    op_i = 6'b000010;
    step(); step();
    chk("j_state", state_o, 9); chk("j_pcw", pc_write_o, 1); chk("j_src", pc_src_o, 2);
    step(); chk("j_done", state_o, 0);

    // illegal opcode; stall FETCH afterwards to show a one-cycle pulse
    op_i = 6'b111111;
    step(); chk("ill_dec", state_o, 1); chk("ill_dec_flag", illegal_o, 0);
    mem_ready_i = 1'b0;
    step(); chk("ill_fetch", state_o, 0); chk("ill_flag", illegal_o, 1);
    chk("ill_rw", reg_write_o, 0); chk("ill_mw", mem_write_o, 0);
    step(); chk("ill_flag_clr", illegal_o, 0); chk("ill_stall", state_o, 0);

    // reset in MEMRD stall
    op_i = 6'b100011; mem_ready_i = 1'b1;
    step(); step(); step();
    chk("rrd_state", state_o, 3);
    mem_ready_i = 1'b0;
    step(); chk("rrd_stall", state_o, 3); chk("rrd_mrd", mem_read_o, 1);
    #1 rst_i = 1'b0;
    #1;
    chk("rrd_async_state", state_o, 0); chk("rrd_mrd0", mem_read_o, 0);
    chk("rrd_mw0", mem_write_o, 0); chk("rrd_rw0", reg_write_o, 0);
    chk("rrd_irw0", ir_write_o, 0); chk("rrd_pcw0", pc_write_o, 0);
    mem_ready_i = 1'b1;
    #1; chk("rrd_pcw_rdy", pc_write_o, 0);
    rst_i = 1'b1;
    #1; chk("rrd_rel_mrd", mem_read_o, 1);
    step(); chk("rrd_resume", state_o, 1);
    step(); step(); step(); step(); chk("rrd_lw_done", state_o, 0);

    // slti then R-type; op changes in IWB must be ignored
    op_i = 6'b001010;
    step(); step();
    chk("slti_state", state_o, 10); chk("slti_alu", ALUOp_o, 3);
    chk("slti_srcb", alu_src_b_o, 2);
    op_i = 6'b000000;
    step(); chk("slti_wb", state_o, 11); chk("slti_wb_rw", reg_write_o, 1);
    chk("slti_wb_dst", reg_dst_o, 0);
    step(); chk("slti_done", state_o, 0);
    step(); step();
    chk("r_state", state_o, 6); chk("r_alu", ALUOp_o, 2); chk("r_srcb", alu_src_b_o, 0);
    step(); chk("r_wb", state_o, 7); chk("r_wb_dst", reg_dst_o, 1);
    chk("r_wb_rw", reg_write_o, 1);
    step(); chk("r_done", state_o, 0);

    // addi
    op_i = 6'b001000;
    step(); step();
    chk("addi_state", state_o, 10); chk("addi_alu", ALUOp_o, 0);
    step(); step(); chk("addi_done", state_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1);
  end
endmodule
